// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: bit-rate divisors, frame length and the shifter
// state type. Also used by the receiver side.
package rs232_pkg;

    localparam int LIMIT_FAST = 217;   // 115200 Bd at 25 MHz
    localparam int LIMIT_SLOW = 1302;  // 19200 Bd at 25 MHz
    localparam int FRAME_LEN  = 10;    // 8N1: start + 8 data + stop
    localparam int TICK_W_MIN = 11;    // minimum width of the bit tick counter

    typedef logic [0:0] tx_state_t;
    localparam tx_state_t ST_IDLE  = 1'b0;
    localparam tx_state_t ST_SHIFT = 1'b1;

    // 8N1 frame, transmitted from bit 0 upwards: start(0), data LSB first, stop(1).
    function automatic logic [FRAME_LEN-1:0] make_frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

endpackage

// File: rtl/rs232t_fifo.sv
// Transmit byte FIFO. Pushes while full and pops while empty are ignored, so
// the caller may drive push/pop as raw requests. Storage is not reset.
module rs232t_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full/empty are taken from the count before the edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/rs232t.sv
// RS-232 8N1 transmitter with a small byte FIFO. Bytes are framed and shifted
// out LSB first on TxD; frames queued back to back leave no mark gap.
//
// Write handshake: a byte on data is taken on a rising edge where start=1 and
// rdy=1 (rdy is FIFO-not-full, valid before the edge). start with rdy=0 is
// simply dropped; there is no retry or error indication.
module rs232t #(
    parameter int DEPTH      = 4,
    parameter int LIMIT_FAST = rs232_pkg::LIMIT_FAST,
    parameter int LIMIT_SLOW = rs232_pkg::LIMIT_SLOW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            data,
    input  logic                  fsel,
    output logic                  rdy,
    output logic                  busy,
    output logic                  TxD,
    output rs232_pkg::tx_state_t  dbg_state_o
);

    import rs232_pkg::*;

    localparam int LIM_MAX = (LIMIT_FAST > LIMIT_SLOW) ? LIMIT_FAST : LIMIT_SLOW;
    localparam int TW      = ($clog2(LIM_MAX) > TICK_W_MIN) ? $clog2(LIM_MAX) : TICK_W_MIN;

    tx_state_t              state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [TW-1:0]          lim_q, lim_d;      // LIMIT-1 of the frame in flight
    logic [3:0]             bitcnt_q, bitcnt_d;
    logic [FRAME_LEN-1:0]   shreg_q, shreg_d;  // bit 0 is the bit now on the line
    logic                   txd_q, txd_d;

    logic [7:0]             fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_pop;
    logic [FRAME_LEN-1:0]   new_frame;
    logic                   bit_end;
    logic                   frame_end;
    logic                   load;

    rs232t_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (start),
        .pop_i   (fifo_pop),
        .wdata_i (data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign new_frame   = make_frame(fifo_rdata);
    assign bit_end     = (tick_q == lim_q);
    assign frame_end   = (state_q == ST_SHIFT) && bit_end && (bitcnt_q == 4'(FRAME_LEN - 1));
    // A new frame is loaded from idle, or on the edge the previous stop bit ends.
    assign load        = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

    assign rdy         = !fifo_full;
    assign busy        = (state_q == ST_SHIFT) || (fifo_count != '0);
    assign TxD         = txd_q;
    assign dbg_state_o = state_q;

    // Shifter next state: load, advance a bit, or return to idle after the stop bit.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        lim_d    = lim_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        if (load) begin
            fifo_pop = 1'b1;
            state_d  = ST_SHIFT;
            tick_d   = '0;
            bitcnt_d = '0;
            shreg_d  = new_frame;
            txd_d    = new_frame[0];
            // Bit rate is latched here and held for the whole frame.
            lim_d    = fsel ? TW'(LIMIT_FAST - 1) : TW'(LIMIT_SLOW - 1);
        end else if (frame_end) begin
            state_d  = ST_IDLE;
            tick_d   = '0;
            bitcnt_d = '0;
            txd_d    = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            if (bit_end) begin
                tick_d   = '0;
                bitcnt_d = bitcnt_q + 4'd1;
                shreg_d  = {1'b1, shreg_q[FRAME_LEN-1:1]};
                txd_d    = shreg_q[1];
            end else begin
                tick_d   = tick_q + TW'(1);
            end
        end
    end

    // Shifter registers; reset truncates any frame and parks the line at mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            lim_q    <= TW'(LIMIT_FAST - 1);
            bitcnt_q <= '0;
            shreg_q  <= '1;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            lim_q    <= lim_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
        end
    end

endmodule
